// File: rtl/csr_access_sequencer.sv
// Single-master front end for the machine-mode CSR access port: arbitrates pipeline,
// trap-entry and MRET requests and sequences their CSR accesses over the en/busy handshake.
module csr_access_sequencer #(
  parameter int unsigned CSR_DATA_WIDTH = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      pipe_req_i,
  input  logic                      pipe_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] pipe_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] pipe_data_i,
  output logic                      pipe_ack_o,
  output logic [CSR_DATA_WIDTH-1:0] pipe_rdata_o,
  input  logic                      trap_req_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_tval_i,
  output logic                      trap_ack_o,
  output logic [CSR_DATA_WIDTH-1:0] trap_vector_o,
  input  logic                      mret_req_i,
  output logic                      mret_ack_o,
  output logic [CSR_DATA_WIDTH-1:0] mret_pc_o,
  output logic                      csr_en_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  input  logic                      csr_busy_i,
  output logic                      timeout_o
);

  localparam int unsigned DW    = CSR_DATA_WIDTH;
  localparam int unsigned AW    = CSR_ADDR_WIDTH;
  localparam int unsigned CNT_W = 8;

  localparam logic [AW-1:0] MSR_MTVEC  = AW'(12'h305);
  localparam logic [AW-1:0] MSR_MEPC   = AW'(12'h341);
  localparam logic [AW-1:0] MSR_MCAUSE = AW'(12'h342);
  localparam logic [AW-1:0] MSR_MTVAL  = AW'(12'h343);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       STEP_LAST = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_PIPE, OP_TRAP, OP_MRET} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        step_q, step_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic [DW-1:0]     cause_q, cause_d;
  logic [DW-1:0]     tval_q, tval_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              csr_en_q, csr_en_d;
  logic              csr_we_q, csr_we_d;
  logic [AW-1:0]     csr_addr_q, csr_addr_d;
  logic [DW-1:0]     csr_data_q, csr_data_d;
  logic              pipe_ack_q, pipe_ack_d;
  logic              trap_ack_q, trap_ack_d;
  logic              mret_ack_q, mret_ack_d;
  logic              timeout_q, timeout_d;
  logic [DW-1:0]     pipe_rdata_q, pipe_rdata_d;
  logic [DW-1:0]     trap_vector_q, trap_vector_d;
  logic [DW-1:0]     mret_pc_q, mret_pc_d;

  logic              acc_we;
  logic [AW-1:0]     acc_addr;
  logic [DW-1:0]     acc_data;
  logic              cur_rd;
  logic              complete;

  // Handler PC: base of MTVEC, plus 4*cause for vectored-mode interrupts.
  function automatic logic [DW-1:0] vector_f(input logic [DW-1:0] v, input logic [DW-1:0] c);
    logic [DW-1:0] base;
    base = {v[DW-1:2], 2'b00};
    if (v[1:0] == 2'b01 && c[DW-1]) begin
      return base + {c[DW-3:0], 2'b00};
    end
    return base;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= OP_PIPE;
      step_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      pc_q          <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      csr_en_q      <= 1'b0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_data_q    <= '0;
      pipe_ack_q    <= 1'b0;
      trap_ack_q    <= 1'b0;
      mret_ack_q    <= 1'b0;
      timeout_q     <= 1'b0;
      pipe_rdata_q  <= '0;
      trap_vector_q <= '0;
      mret_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      step_q        <= step_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      csr_en_q      <= csr_en_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      csr_data_q    <= csr_data_d;
      pipe_ack_q    <= pipe_ack_d;
      trap_ack_q    <= trap_ack_d;
      mret_ack_q    <= mret_ack_d;
      timeout_q     <= timeout_d;
      pipe_rdata_q  <= pipe_rdata_d;
      trap_vector_q <= trap_vector_d;
      mret_pc_q     <= mret_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    step_d        = step_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    csr_en_d      = 1'b0;
    csr_we_d      = 1'b0;
    csr_addr_d    = csr_addr_q;
    csr_data_d    = csr_data_q;
    pipe_ack_d    = 1'b0;
    trap_ack_d    = 1'b0;
    mret_ack_d    = 1'b0;
    timeout_d     = 1'b0;
    pipe_rdata_d  = pipe_rdata_q;
    trap_vector_d = trap_vector_q;
    mret_pc_d     = mret_pc_q;
    acc_we        = 1'b0;
    acc_addr      = csr_addr_q;
    acc_data      = csr_data_q;
    complete      = 1'b0;
    cur_rd        = (op_q == OP_MRET) || (op_q == OP_TRAP && step_q == STEP_LAST) ||
                    (op_q == OP_PIPE && !we_q);

    case (state_q)
      S_IDLE: begin
        if (trap_req_i || mret_req_i || pipe_req_i) begin
          addr_d  = pipe_addr_i;
          wdata_d = pipe_data_i;
          we_d    = pipe_we_i;
          pc_d    = trap_pc_i;
          cause_d = trap_cause_i;
          tval_d  = trap_tval_i;
          step_d  = '0;
          state_d = S_ISSUE;
          if (trap_req_i)      op_d = OP_TRAP;
          else if (mret_req_i) op_d = OP_MRET;
          else                 op_d = OP_PIPE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter at its limit wins over a late busy drop so timeout_o and data agree.
        if (cnt_q == TO_LAST) begin
          complete = 1'b1;
          rdata_d  = '0;
        end else if (csr_busy_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TO_PRE) timeout_d = 1'b1;
        end else begin
          complete = 1'b1;
          rdata_d  = cur_rd ? csr_data_i : '0;
        end
        if (complete) begin
          if (op_q == OP_TRAP && step_q != STEP_LAST) begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (op_d)
      OP_TRAP: begin
        case (step_d)
          2'd0:    begin acc_we = 1'b1; acc_addr = MSR_MEPC;   acc_data = pc_d;    end
          2'd1:    begin acc_we = 1'b1; acc_addr = MSR_MCAUSE; acc_data = cause_d; end
          2'd2:    begin acc_we = 1'b1; acc_addr = MSR_MTVAL;  acc_data = tval_d;  end
          default: begin acc_we = 1'b0; acc_addr = MSR_MTVEC;                      end
        endcase
      end
      OP_MRET: begin
        acc_we   = 1'b0;
        acc_addr = MSR_MEPC;
      end
      default: begin
        acc_we   = we_d;
        acc_addr = addr_d;
        acc_data = wdata_d;
      end
    endcase

    if (state_d == S_ISSUE) begin
      csr_en_d   = 1'b1;
      csr_we_d   = acc_we;
      csr_addr_d = acc_addr;
      csr_data_d = acc_data;
    end

    if (state_d == S_DONE) begin
      case (op_q)
        OP_TRAP: begin trap_ack_d = 1'b1; trap_vector_d = vector_f(rdata_d, cause_q); end
        OP_MRET: begin mret_ack_d = 1'b1; mret_pc_d = rdata_d;                        end
        default: begin pipe_ack_d = 1'b1; pipe_rdata_d = rdata_d;                     end
      endcase
    end
  end

  assign csr_en_o      = csr_en_q;
  assign csr_we_o      = csr_we_q;
  assign csr_addr_o    = csr_addr_q;
  assign csr_data_o    = csr_data_q;
  assign pipe_ack_o    = pipe_ack_q;
  assign trap_ack_o    = trap_ack_q;
  assign mret_ack_o    = mret_ack_q;
  assign timeout_o     = timeout_q;
  assign pipe_rdata_o  = pipe_rdata_q;
  assign trap_vector_o = trap_vector_q;
  assign mret_pc_o     = mret_pc_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench for csr_access_sequencer: directed requests push expected CSR accesses
// and acks; a negedge monitor pops and compares whenever the DUT presents them.
module tb_csr_access_sequencer;

  localparam int K_PIPE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;
  localparam int K_TO   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pipe_req_i = 1'b0, pipe_we_i = 1'b0;
  logic [11:0] pipe_addr_i = '0;
  logic [31:0] pipe_data_i = '0;
  logic        pipe_ack_o;
  logic [31:0] pipe_rdata_o;
  logic        trap_req_i = 1'b0;
  logic [31:0] trap_pc_i = '0, trap_cause_i = '0, trap_tval_i = '0;
  logic        trap_ack_o;
  logic [31:0] trap_vector_o;
  logic        mret_req_i = 1'b0;
  logic        mret_ack_o;
  logic [31:0] mret_pc_o;
  logic        csr_en_o, csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic [31:0] csr_data_i;
  logic        csr_busy_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {bit we; logic [11:0] addr; logic [31:0] data; bit cd; int c;} acc_t;
  typedef struct {int kind; logic [31:0] data; bit cd; int c;} resp_t;
  acc_t  exp_acc[$];
  resp_t exp_resp[$];

  csr_access_sequencer #(.CSR_DATA_WIDTH(32), .CSR_ADDR_WIDTH(12), .TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipe_req_i(pipe_req_i), .pipe_we_i(pipe_we_i), .pipe_addr_i(pipe_addr_i),
    .pipe_data_i(pipe_data_i), .pipe_ack_o(pipe_ack_o), .pipe_rdata_o(pipe_rdata_o),
    .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .trap_tval_i(trap_tval_i), .trap_ack_o(trap_ack_o), .trap_vector_o(trap_vector_o),
    .mret_req_i(mret_req_i), .mret_ack_o(mret_ack_o), .mret_pc_o(mret_pc_o),
    .csr_en_o(csr_en_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .csr_data_i(csr_data_i), .csr_busy_i(csr_busy_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // CSR unit model: busy for busy_len cycles after each en, or forever while hold_busy.
  logic [31:0] csr_mem [4096];
  int busy_len = 1;
  bit hold_busy = 1'b0;
  int rem = 0;
  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_busy_i = 1'b0;
    csr_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        rem = 0;
        csr_busy_i = 1'b0;
      end else if (csr_en_o) begin
        if (csr_we_o) csr_mem[csr_addr_o] = csr_data_o;
        csr_data_i = csr_mem[csr_addr_o];
        rem = busy_len;
        csr_busy_i = 1'b1;
      end else begin
        csr_busy_i = hold_busy || (rem > 0);
        if (rem > 0) rem--;
      end
    end
  end

  task automatic resp_seen(input int kind, input string nm, input logic [31:0] data);
    resp_t e;
    n_checks++;
    if (exp_resp.size() == 0) begin
      n_errors++;
      $display("FAIL %s unexpected: got pulse expected none (cycle %0d)", nm, cyc);
    end else begin
      e = exp_resp.pop_front();
      chk({nm, " kind"}, 32'(kind), 32'(e.kind));
      chk({nm, " cycle"}, 32'(cyc), 32'(e.c));
      if (e.cd) chk({nm, " data"}, data, e.data);
    end
  endtask

  // Monitor: compares every DUT-presented access and response against the queues.
  initial begin
    acc_t a;
    forever begin
      @(negedge clk_i);
      if (csr_en_o) begin
        n_checks++;
        if (exp_acc.size() == 0) begin
          n_errors++;
          $display("FAIL csr access unexpected: got addr %h expected none (cycle %0d)", csr_addr_o, cyc);
        end else begin
          a = exp_acc.pop_front();
          chk("acc cycle", 32'(cyc), 32'(a.c));
          chk("acc we", 32'(csr_we_o), 32'(a.we));
          chk("acc addr", 32'(csr_addr_o), 32'(a.addr));
          if (a.cd) chk("acc data", csr_data_o, a.data);
        end
      end
      if (pipe_ack_o) resp_seen(K_PIPE, "pipe_ack", pipe_rdata_o);
      if (trap_ack_o) resp_seen(K_TRAP, "trap_ack", trap_vector_o);
      if (mret_ack_o) resp_seen(K_MRET, "mret_ack", mret_pc_o);
      if (timeout_o)  resp_seen(K_TO, "timeout", 32'h0);
    end
  end

  task automatic push_acc(input bit we, input logic [11:0] addr, input logic [31:0] data,
                          input bit cd, input int c);
    acc_t a;
    a.we = we; a.addr = addr; a.data = data; a.cd = cd; a.c = c;
    exp_acc.push_back(a);
  endtask

  task automatic push_resp(input int kind, input logic [31:0] data, input bit cd, input int c);
    resp_t r;
    r.kind = kind; r.data = data; r.cd = cd; r.c = c;
    exp_resp.push_back(r);
  endtask

  task automatic wait_pipe();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (pipe_ack_o) break;
    end
    chk("pipe_ack arrives", 32'(pipe_ack_o), 32'd1);
    pipe_req_i = 1'b0;
  endtask

  task automatic wait_trap();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (trap_ack_o) break;
    end
    chk("trap_ack arrives", 32'(trap_ack_o), 32'd1);
    trap_req_i = 1'b0;
  endtask

  task automatic wait_mret();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (mret_ack_o) break;
    end
    chk("mret_ack arrives", 32'(mret_ack_o), 32'd1);
    mret_req_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " csr_en"}, 32'(csr_en_o), 32'd0);
    chk({tag, " csr_we"}, 32'(csr_we_o), 32'd0);
    chk({tag, " acks"}, 32'({pipe_ack_o, trap_ack_o, mret_ack_o}), 32'd0);
    chk({tag, " timeout"}, 32'(timeout_o), 32'd0);
    chk({tag, " csr_addr"}, 32'(csr_addr_o), 32'd0);
    chk({tag, " csr_data"}, csr_data_o, 32'd0);
    chk({tag, " pipe_rdata"}, pipe_rdata_o, 32'd0);
    chk({tag, " trap_vector"}, trap_vector_o, 32'd0);
    chk({tag, " mret_pc"}, mret_pc_o, 32'd0);
  endtask

  task automatic trap_drive(input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval, input int c);
    trap_pc_i = pc; trap_cause_i = cause; trap_tval_i = tval; trap_req_i = 1'b1;
    push_acc(1'b1, 12'h341, pc, 1'b1, c + 1);
    push_acc(1'b1, 12'h342, cause, 1'b1, c + 4);
    push_acc(1'b1, 12'h343, tval, 1'b1, c + 7);
    push_acc(1'b0, 12'h305, 32'h0, 1'b0, c + 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Pipe write MSCRATCH then read it back.
    c = cyc;
    pipe_we_i = 1'b1; pipe_addr_i = 12'h340; pipe_data_i = 32'hDEADBEEF; pipe_req_i = 1'b1;
    push_acc(1'b1, 12'h340, 32'hDEADBEEF, 1'b1, c + 1);
    push_resp(K_PIPE, 32'h0, 1'b0, c + 4);
    wait_pipe();
    @(negedge clk_i);
    c = cyc;
    pipe_we_i = 1'b0; pipe_data_i = 32'h0; pipe_req_i = 1'b1;
    push_acc(1'b0, 12'h340, 32'h0, 1'b1, c + 1);
    push_resp(K_PIPE, 32'hDEADBEEF, 1'b1, c + 4);
    wait_pipe();

    // Direct-mode trap.
    @(negedge clk_i);
    csr_mem[12'h305] = 32'h100;
    c = cyc;
    trap_drive(32'h40, 32'h2, 32'h1234, c);
    push_resp(K_TRAP, 32'h100, 1'b1, c + 13);
    wait_trap();

    // Vectored-mode interrupt.
    @(negedge clk_i);
    csr_mem[12'h305] = 32'h201;
    c = cyc;
    trap_drive(32'h80, 32'h80000007, 32'h0, c);
    push_resp(K_TRAP, 32'h21C, 1'b1, c + 13);
    wait_trap();

    // MRET returns the MEPC written by the last trap.
    @(negedge clk_i);
    c = cyc;
    mret_req_i = 1'b1;
    push_acc(1'b0, 12'h341, 32'h0, 1'b0, c + 1);
    push_resp(K_MRET, 32'h80, 1'b1, c + 4);
    wait_mret();

    // All three at once: trap, then mret, then pipe.
    @(negedge clk_i);
    c = cyc;
    trap_drive(32'h300, 32'h3, 32'h55, c);
    mret_req_i = 1'b1;
    pipe_we_i = 1'b0; pipe_addr_i = 12'h340; pipe_data_i = 32'h0; pipe_req_i = 1'b1;
    push_acc(1'b0, 12'h341, 32'h0, 1'b0, c + 15);
    push_acc(1'b0, 12'h340, 32'h0, 1'b1, c + 20);
    push_resp(K_TRAP, 32'h200, 1'b1, c + 13);
    push_resp(K_MRET, 32'h300, 1'b1, c + 18);
    push_resp(K_PIPE, 32'hDEADBEEF, 1'b1, c + 23);
    fork
      wait_trap();
      wait_mret();
      wait_pipe();
    join

    // Three busy cycles stretch a pipe write by two.
    @(negedge clk_i);
    busy_len = 3;
    c = cyc;
    pipe_we_i = 1'b1; pipe_addr_i = 12'h340; pipe_data_i = 32'h12345678; pipe_req_i = 1'b1;
    push_acc(1'b1, 12'h340, 32'h12345678, 1'b1, c + 1);
    push_resp(K_PIPE, 32'h0, 1'b0, c + 6);
    wait_pipe();
    busy_len = 1;

    // Busy stuck high: timeout after 15 WAIT cycles, ack with zero data.
    @(negedge clk_i);
    hold_busy = 1'b1;
    c = cyc;
    pipe_we_i = 1'b0; pipe_data_i = 32'h0; pipe_req_i = 1'b1;
    push_acc(1'b0, 12'h340, 32'h0, 1'b1, c + 1);
    push_resp(K_TO, 32'h0, 1'b0, c + 17);
    push_resp(K_PIPE, 32'h0, 1'b1, c + 18);
    wait_pipe();
    hold_busy = 1'b0;

    // Reset during the MCAUSE access of a trap.
    @(negedge clk_i);
    c = cyc;
    trap_pc_i = 32'h444; trap_cause_i = 32'h5; trap_tval_i = 32'h6; trap_req_i = 1'b1;
    push_acc(1'b1, 12'h341, 32'h444, 1'b1, c + 1);
    push_acc(1'b1, 12'h342, 32'h5, 1'b1, c + 4);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    trap_req_i = 1'b0;
    #1;
    chk_reset_outputs("mid-trap reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    c = cyc;
    pipe_we_i = 1'b0; pipe_addr_i = 12'h340; pipe_req_i = 1'b1;
    push_acc(1'b0, 12'h340, 32'h0, 1'b1, c + 1);
    push_resp(K_PIPE, 32'h12345678, 1'b1, c + 4);
    wait_pipe();

    repeat (5) @(negedge clk_i);
    chk("access queue drained", 32'(exp_acc.size()), 32'd0);
    chk("response queue drained", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Front-end controller for the machine-mode CSR unit. It shares the unit's single access port between three requesters: the pipeline (CSRRx instructions), the trap unit (exception/interrupt entry) and the MRET path. It also sequences the multi-access trap-entry and return flows. All downstream accesses go through the CSR unit's one-cycle `csr_en` / `csr_busy` handshake; this block is the only master of that port.

## Interface
Parameters:
- `CSR_DATA_WIDTH`, 32, CSR data width.
- `CSR_ADDR_WIDTH`, 12, CSR address width.
- `TIMEOUT_CYCLES`, 15, maximum WAIT cycles with `csr_busy_i` high before an access is forced complete. Range 1..255.

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pipe_req_i` / `pipe_we_i`  in  1 / 1  pipeline request and write enable.
- `pipe_addr_i`  in  `CSR_ADDR_WIDTH`  pipeline CSR address.
- `pipe_data_i`  in  `CSR_DATA_WIDTH`  pipeline write data.
- `pipe_ack_o`  out  1  one-cycle completion pulse.
- `pipe_rdata_o`  out  `CSR_DATA_WIDTH`  read data, valid with ack and held until the next ack.
- `trap_req_i`  in  1  trap entry request.
- `trap_pc_i` / `trap_cause_i` / `trap_tval_i`  in  `CSR_DATA_WIDTH` each  values written to MEPC / MCAUSE / MTVAL.
- `trap_ack_o`  out  1  completion pulse.
- `trap_vector_o`  out  `CSR_DATA_WIDTH`  computed handler PC, valid with `trap_ack_o` and held.
- `mret_req_i` / `mret_ack_o`  in / out  1 / 1  MRET request / completion pulse.
- `mret_pc_o`  out  `CSR_DATA_WIDTH`  MEPC value, valid with ack and held.
- `csr_en_o` / `csr_we_o`  out  1 / 1  to the CSR unit.
- `csr_addr_o` / `csr_data_o`  out  `CSR_ADDR_WIDTH` / `CSR_DATA_WIDTH`  to the CSR unit.
- `csr_data_i` / `csr_busy_i`  in  `CSR_DATA_WIDTH` / 1  from the CSR unit.
- `timeout_o`  out  1  one-cycle pulse when an access times out.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **Operation register `op`:** PIPE, TRAP or MRET.
- **Step counter:** 2 bits, selects the access within a flow.
- **Arbitration (IDLE only):** fixed priority trap > mret > pipe.
  - On grant, latch all request fields: address, data, we, pc, cause, tval.
  - Requesters must hold `req` until their ack. Input changes after grant are ignored.
- **Flows:**
  - PIPE: one access with pipe address, data and we.
  - TRAP: four accesses in order:
    1. write `MSR_MEPC` ← pc
    2. write `MSR_MCAUSE` ← cause
    3. write `MSR_MTVAL` ← tval
    4. read `MSR_MTVEC`
  - MRET: one read of `MSR_MEPC`.
- **ISSUE:** drive `csr_en_o`=1 with `csr_we_o`, `csr_addr_o`, `csr_data_o` for exactly one cycle, then go to WAIT. Clear the timeout counter.
- **WAIT:**
  - While `csr_busy_i`=1: stay and increment the timeout counter.
  - When `csr_busy_i`=0: the access completes that cycle. If it is a read, capture `csr_data_i`.
  - When the counter reaches `TIMEOUT_CYCLES`: complete with captured data forced to 0 and pulse `timeout_o`. The flow continues.
  - After completion: go to ISSUE if the flow has more steps, otherwise DONE.
- **DONE:** pulse the matching ack for one cycle with its data output updated that cycle. Return to IDLE.
- **Trap vector:** let `v` be the captured MTVEC.
  - If `v[1:0]`==2'b01 and `cause[31]`=1: vector = `{v[31:2],2'b00} + (cause[29:0] << 2)`, modulo 2^32 (wrap ignored).
  - Otherwise: vector = `{v[31:2],2'b00}`.
- **Pipe write data:** the pipeline's own data is passed through unmodified. Read-modify-write set/clear is the pipeline's job.
- **Outside ISSUE:** `csr_en_o`=0 and `csr_we_o`=0. Address and data outputs hold the last driven values.

## Timing
- **Reset values:**
  - State IDLE.
  - `csr_en_o`, `csr_we_o`, all acks and `timeout_o` = 0.
  - `csr_addr_o`, `csr_data_o`, `pipe_rdata_o`, `trap_vector_o`, `mret_pc_o` = 0.
- **Reset mid-flow:** aborts immediately, asynchronously. No ack is issued and partial trap writes are not undone.
- **Latency** (request seen in IDLE at cycle 0, CSR busy for exactly 1 cycle after en):
  - PIPE: en at cycle 1, complete at cycle 3, `pipe_ack_o` at cycle 4.
  - MRET: ack at cycle 4.
  - TRAP: en at cycles 1, 4, 7, 10; ack at cycle 13.
- **Longer busy:** each extra busy cycle adds one cycle per access.
- **Back-to-back:** a request still asserted in the cycle after its ack (IDLE) is granted again. Requesters drop `req` in the ack cycle to avoid duplicates.
- **Simultaneous requests:** the loser waits in its request. An in-progress flow is never pre-empted, including a trap arriving during a PIPE access.
- **Busy already high:** `csr_busy_i` high in ISSUE is ignored. Completion is judged only in WAIT.

## Test plan
- **Pipe write then read:** pipe write `MSR_MSCRATCH` = 0xDEADBEEF, then read.
  - Expect `csr_en_o` pulses at cycles 1 and 6 (second grant at cycle 5).
  - Expect `pipe_ack_o` at cycles 4 and 9, with `pipe_rdata_o`=0xDEADBEEF on the second.
- **Direct-mode trap:** MTVEC=0x100, trap with pc=0x40, cause=0x2, tval=0x1234.
  - Expect writes in order MEPC/MCAUSE/MTVAL with those values, then an MTVEC read.
  - Expect `trap_ack_o` at cycle 13 with `trap_vector_o`=0x100.
- **Vectored trap:** MTVEC=0x201, cause=0x80000007 → `trap_vector_o`=0x21C.
- **Arbitration:** trap, mret and pipe requested in the same cycle → grant order trap, mret, pipe. Each ack fires only after the previous flow's DONE.
- **Timeout:** hold `csr_busy_i`=1 forever during a pipe read.
  - Expect `timeout_o` pulse after 15 WAIT cycles.
  - Expect `pipe_ack_o` next cycle with `pipe_rdata_o`=0.
- **Reset mid-trap:** assert `rst_i` during step 2 of a trap.
  - Expect all outputs at reset values immediately and no `trap_ack_o`.
  - After release, a fresh pipe request completes at cycle 4.
